// File: rtl/xip_pkg.sv
// Shared definitions for the XIP AHB-Lite front end: FSM encoding, AHB codes
// and the line-offset width helper.
package xip_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        WAIT = 3'd2,
        FILL = 3'd3,
        DONE = 3'd4,
        ERR1 = 3'd5,
        ERR2 = 3'd6
    } xip_state_e;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    // Number of byte-offset bits inside one cache line (ceil(log2)).
    function automatic int line_off_w(input int line_size);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < line_size) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/xip_sat_counter.sv
// Saturating event counter: increments on inc, holds at all-ones.
module xip_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != {CNT_W{1'b1}})) begin
            count <= count + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/xip_ahbl_ctrl.sv
// AHB-Lite slave front end for the QSPI XIP path: zero-wait cache hits,
// stalled line fills on misses, two-cycle ERROR response for writes.
module xip_ahbl_ctrl
    import xip_pkg::*;
#(
    parameter int LINE_SIZE = 16,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             HSEL,
    input  logic [31:0]      HADDR,
    input  logic [1:0]       HTRANS,
    input  logic             HWRITE,
    input  logic [2:0]       HSIZE,
    input  logic             HREADY,
    output logic             HREADYOUT,
    output logic [31:0]      HRDATA,
    output logic             HRESP,
    output logic [23:0]      c_A,
    output logic [23:0]      c_A_h,
    input  logic             c_hit,
    input  logic [31:0]      c_Do,
    output logic             c_wr,
    output logic [23:0]      fr_addr,
    output logic             fr_rd,
    input  logic             fr_done,
    output logic [CNT_W-1:0] hit_cnt,
    output logic [CNT_W-1:0] miss_cnt
);

    localparam int OFF_W = line_off_w(LINE_SIZE);

    xip_state_e  state;
    logic [23:0] a_q;
    logic        w_q;
    logic        hreadyout_q;
    logic        hresp_q;
    logic        fr_rd_q;
    logic        c_wr_q;

    logic        valid;
    logic        accept;
    logic        hit_inc;
    logic        miss_inc;
    logic        unused_sig;

    assign valid    = HSEL & HREADY & HTRANS[1];
    assign accept   = valid & ((state == IDLE) | (state == DONE));
    assign hit_inc  = accept & ~HWRITE & c_hit;
    assign miss_inc = accept & ~HWRITE & ~c_hit;

    // HSIZE is ignored (full word always returned); upper address bits unmapped.
    assign unused_sig = ^{HADDR[31:24], HTRANS[0], HSIZE, w_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            a_q         <= '0;
            w_q         <= 1'b0;
            hreadyout_q <= 1'b1;
            hresp_q     <= HRESP_OKAY;
            fr_rd_q     <= 1'b0;
            c_wr_q      <= 1'b0;
        end else begin
            fr_rd_q <= 1'b0;
            c_wr_q  <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    state       <= IDLE;
                    hreadyout_q <= 1'b1;
                    hresp_q     <= HRESP_OKAY;
                    if (valid) begin
                        a_q <= HADDR[23:0];
                        w_q <= HWRITE;
                        if (HWRITE) begin
                            state       <= ERR1;
                            hreadyout_q <= 1'b0;
                            hresp_q     <= HRESP_ERROR;
                        end else if (!c_hit) begin
                            state       <= REQ;
                            hreadyout_q <= 1'b0;
                            fr_rd_q     <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    state <= WAIT;
                end
                // No timeout: the first fill after reset waits out the flash reset sequence.
                WAIT: begin
                    if (fr_done) begin
                        state  <= FILL;
                        c_wr_q <= 1'b1;
                    end
                end
                FILL: begin
                    state       <= DONE;
                    hreadyout_q <= 1'b1;
                end
                ERR1: begin
                    state       <= ERR2;
                    hreadyout_q <= 1'b1;
                end
                ERR2: begin
                    state   <= IDLE;
                    hresp_q <= HRESP_OKAY;
                end
                default: begin
                    state       <= IDLE;
                    hreadyout_q <= 1'b1;
                    hresp_q     <= HRESP_OKAY;
                end
            endcase
        end
    end

    assign HREADYOUT = hreadyout_q;
    assign HRESP     = hresp_q;
    assign HRDATA    = c_Do;
    assign fr_rd     = fr_rd_q;
    assign c_wr      = c_wr_q;
    assign c_A       = a_q;
    assign c_A_h     = HADDR[23:0];
    assign fr_addr   = {a_q[23:OFF_W], {OFF_W{1'b0}}};

    xip_sat_counter #(.CNT_W(CNT_W)) u_hit_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (hit_inc),
        .count (hit_cnt)
    );

    xip_sat_counter #(.CNT_W(CNT_W)) u_miss_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (miss_inc),
        .count (miss_cnt)
    );

endmodule

// File: tb/tb_xip_ahbl_ctrl.sv
// Directed bench for xip_ahbl_ctrl with a small direct-mapped cache stand-in.
module tb_xip_ahbl_ctrl;
    import xip_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        HSEL = 1'b0;
    logic [31:0] HADDR = '0;
    logic [1:0]  HTRANS = HTRANS_IDLE;
    logic        HWRITE = 1'b0;
    logic [2:0]  HSIZE = 3'b010;
    logic        HREADY = 1'b1;
    logic        fr_done = 1'b0;
    logic        c_hit;
    logic [31:0] c_Do;

    logic        HREADYOUT, HRESP, c_wr, fr_rd;
    logic [31:0] HRDATA;
    logic [23:0] c_A, c_A_h, fr_addr;
    logic [15:0] hit_cnt, miss_cnt;

    logic        HREADYOUT4, HRESP4, c_wr4, fr_rd4;
    logic [31:0] HRDATA4;
    logic [23:0] c_A4, c_A_h4, fr_addr4;
    logic [3:0]  hit_cnt4, miss_cnt4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    xip_ahbl_ctrl #(.LINE_SIZE(16), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
        .HWRITE(HWRITE), .HSIZE(HSIZE), .HREADY(HREADY), .HREADYOUT(HREADYOUT),
        .HRDATA(HRDATA), .HRESP(HRESP), .c_A(c_A), .c_A_h(c_A_h), .c_hit(c_hit),
        .c_Do(c_Do), .c_wr(c_wr), .fr_addr(fr_addr), .fr_rd(fr_rd),
        .fr_done(fr_done), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    xip_ahbl_ctrl #(.LINE_SIZE(16), .CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
        .HWRITE(HWRITE), .HSIZE(HSIZE), .HREADY(HREADY), .HREADYOUT(HREADYOUT4),
        .HRDATA(HRDATA4), .HRESP(HRESP4), .c_A(c_A4), .c_A_h(c_A_h4), .c_hit(c_hit),
        .c_Do(c_Do), .c_wr(c_wr4), .fr_addr(fr_addr4), .fr_rd(fr_rd4),
        .fr_done(fr_done), .hit_cnt(hit_cnt4), .miss_cnt(miss_cnt4)
    );

    // Cache stand-in: 16 lines of 16 bytes; word data encodes its own address.
    logic        cv   [16];
    logic [15:0] ctag [16];
    logic        flush = 1'b0;

    always @(posedge clk) begin
        if (flush) begin
            for (int i = 0; i < 16; i++) cv[i] <= 1'b0;
        end else if (c_wr) begin
            cv[c_A[7:4]]   <= 1'b1;
            ctag[c_A[7:4]] <= c_A[23:8];
        end
    end

    always_comb begin
        c_hit = 1'b0;
        c_Do  = 32'hBAD0_0000;
        if (cv[c_A_h[7:4]] === 1'b1 && ctag[c_A_h[7:4]] == c_A_h[23:8]) c_hit = 1'b1;
        if (cv[c_A[7:4]] === 1'b1 && ctag[c_A[7:4]] == c_A[23:8]) c_Do = {8'hD0, c_A[23:2], 2'b00};
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle;
        HSEL   = 1'b0;
        HTRANS = HTRANS_IDLE;
        HWRITE = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        flush = 1'b1;
        repeat (3) step();
        checks++; if (HREADYOUT !== 1'b1) begin errors++; $display("FAIL reset_hreadyout got %b exp 1", HREADYOUT); end
        checks++; if (HRESP !== 1'b0) begin errors++; $display("FAIL reset_hresp got %b exp 0", HRESP); end
        checks++; if ({fr_rd, c_wr} !== 2'b00) begin errors++; $display("FAIL reset_strobes got %b exp 00", {fr_rd, c_wr}); end
        checks++; if ({hit_cnt, miss_cnt} !== 32'h0) begin errors++; $display("FAIL reset_counters got %h exp 0", {hit_cnt, miss_cnt}); end
        checks++; if (c_A !== 24'h0) begin errors++; $display("FAIL reset_c_A got %h exp 0", c_A); end
        flush = 1'b0;
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_cold_miss;
        int pulses;
        int wr_early;
        HSEL = 1'b1; HTRANS = HTRANS_NONSEQ; HADDR = 32'h0000_0104; HWRITE = 1'b0;
        step();
        bus_idle();
        checks++; if (fr_rd !== 1'b1) begin errors++; $display("FAIL miss_fr_rd got %b exp 1", fr_rd); end
        checks++; if (fr_addr !== 24'h000100) begin errors++; $display("FAIL miss_fr_addr got %h exp 000100", fr_addr); end
        checks++; if (HREADYOUT !== 1'b0) begin errors++; $display("FAIL miss_stall got %b exp 0", HREADYOUT); end
        checks++; if (miss_cnt !== 16'd1) begin errors++; $display("FAIL miss_cnt got %0d exp 1", miss_cnt); end
        pulses = 0;
        wr_early = 0;
        repeat (40) begin
            step();
            if (fr_rd === 1'b1) pulses++;
            if (c_wr !== 1'b0 || HREADYOUT !== 1'b0) wr_early++;
        end
        checks++; if (pulses != 0) begin errors++; $display("FAIL miss_fr_rd_width got %0d extra exp 0", pulses); end
        checks++; if (wr_early != 0) begin errors++; $display("FAIL miss_wait_hold got %0d bad cycles exp 0", wr_early); end
        fr_done = 1'b1;
        step();
        fr_done = 1'b0;
        checks++; if (c_wr !== 1'b1) begin errors++; $display("FAIL fill_c_wr got %b exp 1", c_wr); end
        checks++; if (HREADYOUT !== 1'b0) begin errors++; $display("FAIL fill_stall got %b exp 0", HREADYOUT); end
        step();
        checks++; if (c_wr !== 1'b0) begin errors++; $display("FAIL done_c_wr got %b exp 0", c_wr); end
        checks++; if (HREADYOUT !== 1'b1) begin errors++; $display("FAIL done_ready got %b exp 1", HREADYOUT); end
        checks++; if (HRDATA !== 32'hD000_0104) begin errors++; $display("FAIL done_hrdata got %h exp d0000104", HRDATA); end
    endtask

    task automatic test_hit_in_done;
        HSEL = 1'b1; HTRANS = HTRANS_NONSEQ; HADDR = 32'h0000_0108; HWRITE = 1'b0;
        step();
        bus_idle();
        checks++; if (HREADYOUT !== 1'b1) begin errors++; $display("FAIL hit_ready got %b exp 1", HREADYOUT); end
        checks++; if (fr_rd !== 1'b0) begin errors++; $display("FAIL hit_fr_rd got %b exp 0", fr_rd); end
        checks++; if (HRDATA !== 32'hD000_0108) begin errors++; $display("FAIL hit_hrdata got %h exp d0000108", HRDATA); end
        checks++; if ({hit_cnt, miss_cnt} !== {16'd1, 16'd1}) begin errors++; $display("FAIL hit_counters got %h exp 00010001", {hit_cnt, miss_cnt}); end
    endtask

    task automatic test_write;
        step();
        HSEL = 1'b1; HTRANS = HTRANS_NONSEQ; HADDR = 32'h0000_0010; HWRITE = 1'b1;
        step();
        bus_idle();
        checks++; if ({HRESP, HREADYOUT, fr_rd} !== 3'b100) begin errors++; $display("FAIL wr_err1 got %b exp 100", {HRESP, HREADYOUT, fr_rd}); end
        step();
        checks++; if ({HRESP, HREADYOUT, fr_rd} !== 3'b110) begin errors++; $display("FAIL wr_err2 got %b exp 110", {HRESP, HREADYOUT, fr_rd}); end
        step();
        checks++; if ({HRESP, HREADYOUT, c_wr} !== 3'b010) begin errors++; $display("FAIL wr_back got %b exp 010", {HRESP, HREADYOUT, c_wr}); end
        checks++; if ({hit_cnt, miss_cnt} !== {16'd1, 16'd1}) begin errors++; $display("FAIL wr_counters got %h exp 00010001", {hit_cnt, miss_cnt}); end
    endtask

    task automatic test_idle_busy;
        for (int i = 0; i < 16; i++) begin
            HADDR  = $urandom;
            HWRITE = 1'($urandom_range(0, 1));
            case (i % 4)
                0: begin HSEL = 1'b1; HTRANS = HTRANS_IDLE;   HREADY = 1'b1; end
                1: begin HSEL = 1'b1; HTRANS = HTRANS_BUSY;   HREADY = 1'b1; end
                2: begin HSEL = 1'b0; HTRANS = HTRANS_NONSEQ; HREADY = 1'b1; end
                default: begin HSEL = 1'b1; HTRANS = HTRANS_NONSEQ; HREADY = 1'b0; end
            endcase
            step();
            checks++;
            if ({HREADYOUT, HRESP, fr_rd, c_wr} !== 4'b1000) begin
                errors++;
                $display("FAIL idle_busy_%0d got %b exp 1000", i, {HREADYOUT, HRESP, fr_rd, c_wr});
            end
        end
        HREADY = 1'b1;
        bus_idle();
        step();
        checks++; if ({hit_cnt, miss_cnt} !== {16'd1, 16'd1}) begin errors++; $display("FAIL idle_counters got %h exp 00010001", {hit_cnt, miss_cnt}); end
    endtask

    task automatic test_reset_in_wait;
        HSEL = 1'b1; HTRANS = HTRANS_NONSEQ; HADDR = 32'h0000_2000; HWRITE = 1'b0;
        step();
        bus_idle();
        checks++; if ({fr_rd, fr_addr} !== {1'b1, 24'h002000}) begin errors++; $display("FAIL rw_req got %h exp 1002000", {fr_rd, fr_addr}); end
        step();
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if ({HREADYOUT, HRESP, fr_rd, c_wr} !== 4'b1000) begin errors++; $display("FAIL rw_async_ctrl got %b exp 1000", {HREADYOUT, HRESP, fr_rd, c_wr}); end
        checks++; if ({hit_cnt, miss_cnt, c_A} !== 56'h0) begin errors++; $display("FAIL rw_async_regs got %h exp 0", {hit_cnt, miss_cnt, c_A}); end
        step();
        rst_n = 1'b1;
        step();
        fr_done = 1'b1;
        step();
        fr_done = 1'b0;
        checks++; if ({c_wr, HREADYOUT} !== 2'b01) begin errors++; $display("FAIL rw_late_done got %b exp 01", {c_wr, HREADYOUT}); end
        step();
        checks++; if ({c_wr, HREADYOUT} !== 2'b01) begin errors++; $display("FAIL rw_late_done2 got %b exp 01", {c_wr, HREADYOUT}); end
    endtask

    task automatic test_saturation;
        int bad;
        bad = 0;
        HSEL = 1'b1; HTRANS = HTRANS_NONSEQ; HADDR = 32'h0000_0104; HWRITE = 1'b0;
        repeat (15) begin
            step();
            if (HREADYOUT !== 1'b1 || HREADYOUT4 !== 1'b1 || fr_rd !== 1'b0) bad++;
        end
        checks++; if (hit_cnt4 !== 4'd15) begin errors++; $display("FAIL sat_at15 got %0d exp 15", hit_cnt4); end
        checks++; if (hit_cnt !== 16'd15) begin errors++; $display("FAIL sat_wide15 got %0d exp 15", hit_cnt); end
        repeat (5) begin
            step();
            if (HREADYOUT !== 1'b1 || HREADYOUT4 !== 1'b1 || fr_rd !== 1'b0) bad++;
        end
        bus_idle();
        checks++; if (bad != 0) begin errors++; $display("FAIL sat_zero_wait got %0d bad cycles exp 0", bad); end
        checks++; if (hit_cnt4 !== 4'd15) begin errors++; $display("FAIL sat_stick got %0d exp 15", hit_cnt4); end
        checks++; if (hit_cnt !== 16'd20) begin errors++; $display("FAIL sat_wide20 got %0d exp 20", hit_cnt); end
        checks++; if ({miss_cnt4, miss_cnt} !== 20'h0) begin errors++; $display("FAIL sat_miss got %h exp 0", {miss_cnt4, miss_cnt}); end
        checks++; if (HRDATA !== 32'hD000_0104) begin errors++; $display("FAIL sat_hrdata got %h exp d0000104", HRDATA); end
        step();
    endtask

    initial begin
        test_reset();
        test_cold_miss();
        test_hit_in_done();
        test_write();
        test_idle_busy();
        test_reset_in_wait();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
